// File: rtl/alu_rr_scheduler_if.sv
// Requester/response bus of the shared-ALU scheduler.
// master = requesters plus response consumer, slave = scheduler.
interface alu_rr_scheduler_if #(
  parameter int NUM_REQ = 4
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ*8-1:0] req_a;
  logic [NUM_REQ*8-1:0] req_b;
  logic [NUM_REQ*4-1:0] req_op;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [ID_W-1:0]      rsp_id;
  logic [7:0]           rsp_data;
  logic                 rsp_carry;
  logic                 rsp_err;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_err
  );
endinterface

// File: rtl/alu_rr_scheduler.sv
// Round-robin scheduler sharing one registered 8-bit ALU among NUM_REQ requesters.
// Optional macro ALU_DIV_GUARD_EN: divide-by-zero is answered locally with an error response.
module alu_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int ALU_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_rr_scheduler_if.slave bus,
  output logic [7:0]        alu_a,
  output logic [7:0]        alu_b,
  output logic [3:0]        alu_opcode,
  input  logic [7:0]        alu_out,
  input  logic              alu_carry
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(ALU_LAT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_nxt;

  logic [NUM_REQ-1:0][7:0] lane_a, lane_b;
  logic [NUM_REQ-1:0][3:0] lane_op;
  logic [NUM_REQ-1:0]      req_ready;
  logic [ID_W-1:0]         rr_ptr, grant, cand, rsp_id;
  logic [CNT_W-1:0]        cnt;
  logic [7:0]              rsp_data;
  logic found, xfer, capture, div_byp, div_pend;
  logic rsp_valid, rsp_carry, rsp_err;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign lane_a[i]  = bus.req_a[8*i +: 8];
    assign lane_b[i]  = bus.req_b[8*i +: 8];
    assign lane_op[i] = bus.req_op[4*i +: 4];
  end

  // Scan starts one past the last winner so the previous grantee goes last.
  always_comb begin
    grant = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!found && bus.req_valid[cand]) begin
        found = 1'b1;
        grant = cand;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    xfer      = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: if (found && rst_n) begin
        req_ready[grant] = 1'b1;
        xfer             = 1'b1;
        state_nxt        = WAIT;
      end
      WAIT: if (div_pend || cnt == CNT_W'(ALU_LAT)) begin
        capture   = 1'b1;
        state_nxt = RESP;
      end
      RESP: if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= ID_W'(NUM_REQ - 1);
      rsp_id     <= '0;
      cnt        <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      rsp_data   <= '0;
      rsp_carry  <= 1'b0;
      rsp_valid  <= 1'b0;
    end else begin
      if (xfer) begin
        rr_ptr <= grant;
        rsp_id <= grant;
        cnt    <= '0;
        if (!div_byp) begin
          alu_a      <= lane_a[grant];
          alu_b      <= lane_b[grant];
          alu_opcode <= lane_op[grant];
        end
      end else if (state == WAIT && !capture) begin
        cnt <= cnt + 1'b1;
      end
      if (capture) begin
        rsp_data  <= div_pend ? 8'hFF : alu_out;
        rsp_carry <= div_pend | alu_carry;
        rsp_valid <= 1'b1;
      end else if (state == RESP && bus.rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

`ifdef ALU_DIV_GUARD_EN
  assign div_byp = (lane_op[grant] == 4'b0011) && (lane_b[grant] == 8'h00);

  // ALU operands stay untouched on a bypass; the response is produced one edge later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_pend <= 1'b0;
      rsp_err  <= 1'b0;
    end else begin
      if (xfer)         div_pend <= div_byp;
      else if (capture) div_pend <= 1'b0;
      if (capture)      rsp_err  <= div_pend;
    end
  end
`else
  assign div_byp  = 1'b0;
  assign div_pend = 1'b0;
  assign rsp_err  = 1'b0;
`endif

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_id    = rsp_id;
  assign bus.rsp_data  = rsp_data;
  assign bus.rsp_carry = rsp_carry;
  assign bus.rsp_err   = rsp_err;
endmodule
